// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI constants and state encoding
package spi_pkg;
  localparam int SPI_DATA_WIDTH = 8;
  typedef enum logic {IDLE, ACTIVE} spi_slave_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-flop synchroniser with registered rise/fall strobes
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] stg;
  logic              dly;
  logic [STAGES:0]   warm;
  logic              lvl;
  assign lvl = stg[STAGES-1];
  // edges are masked until every stage and the delayed copy hold real pin samples,
  // so a pin parked at the opposite level out of reset never looks like an edge
  always_ff @(posedge clk)
    if (rst) begin
      stg  <= {STAGES{RST_VAL}};
      dly  <= RST_VAL;
      warm <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      stg  <= {stg[STAGES-2:0], pin};
      dly  <= lvl;
      warm <= {warm[STAGES-1:0], 1'b1};
      rise <= warm[STAGES] && lvl && !dly;
      fall <= warm[STAGES] && !lvl && dly;
    end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled mode-0 SPI target with one-deep tx holding buffer
module spi_slave
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCK_I,
  input  logic       SS_I,
  input  logic       IO0_I,
  output logic       IO1_O,
  output logic       IO1_T,
  input  logic [7:0] spi_tx_data,
  input  logic       spi_tx_valid,
  output logic       spi_tx_ready,
  output logic [7:0] spi_rx_data,
  output logic       spi_rx_valid,
  output logic       spi_tx_underrun
);
  localparam logic [2:0] LAST = 3'(SPI_DATA_WIDTH - 1);
  spi_slave_state_t          state, state_next;
  logic                      sck_rise, sck_fall, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0]    mosi_stg;
  logic                      mosi;
  logic [2:0]                cnt;
  logic [SPI_DATA_WIDTH-1:0] tx_shift, rx_shift, tx_buf;
  logic                      full, load;
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst(rst), .pin(SCK_I), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .pin(SS_I), .rise(ss_rise), .fall(ss_fall));
  assign mosi         = mosi_stg[SYNC_STAGES-1];
  assign spi_tx_ready = !full;
  // MOSI needs only its level, sampled on synchronised SCK rises
  always_ff @(posedge clk)
    mosi_stg <= rst ? '0 : {mosi_stg[SYNC_STAGES-2:0], IO0_I};
  // frame state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_next;
  // SS rise wins over a coinciding SCK fall, so the closing edge of a frame never reloads
  always_comb begin
    state_next = ss_rise ? IDLE : (state == IDLE && ss_fall) ? ACTIVE : state;
    load       = !ss_rise && ((state == IDLE && ss_fall) || (state == ACTIVE && sck_fall && cnt == '0));
    IO1_T      = state != ACTIVE;
    IO1_O      = state == ACTIVE && tx_shift[7];
  end
  // holding buffer, shift registers, bit counter and strobes
  always_ff @(posedge clk)
    if (rst) begin
      full            <= 1'b0;
      tx_buf          <= '0;
      tx_shift        <= '0;
      rx_shift        <= '0;
      cnt             <= '0;
      spi_rx_data     <= '0;
      spi_rx_valid    <= 1'b0;
      spi_tx_underrun <= 1'b0;
    end else begin
      spi_rx_valid    <= 1'b0;
      spi_tx_underrun <= load && !full;
      full            <= (full && !load) || (spi_tx_valid && !full);
      if (spi_tx_valid && !full) tx_buf <= spi_tx_data;
      if (load) tx_shift <= full ? tx_buf : IDLE_TX;
      else if (state == ACTIVE && sck_fall) tx_shift <= {tx_shift[6:0], 1'b0};
      if (state != ACTIVE || ss_rise) cnt <= '0;
      else if (sck_rise) begin
        cnt      <= cnt + 3'd1;
        rx_shift <= {rx_shift[6:0], mosi};
        if (cnt == LAST) begin
          spi_rx_data  <= {rx_shift[6:0], mosi};
          spi_rx_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed mode-0 master with queue-based model of the slave
module tb_spi_slave;
  localparam int         SYNC    = 2;
  localparam int         HALF    = 8;
  localparam logic [7:0] IDLE_TX = 8'h00;
  logic       clk = 0, rst = 1, sck = 0, ss = 1, mosi = 0;
  logic       io1_o, io1_t, tx_ready, rx_valid, underrun;
  logic [7:0] tx_data = 0, rx_data;
  logic       tx_valid = 0;
  int         n_tests = 0, n_fail = 0;
  logic [7:0] acc_q[$], rxq[$];
  int         under_pend = 0, n_under = 0, n_strobe = 0, n_acc = 0;
  logic [7:0] last_rx = 0;
  logic       prev_valid = 0, spin = 0;
  logic [7:0] mtx[4], mrx[4], mexp[4];
  int         s0, u0, a0;

  spi_slave #(.SYNC_STAGES(SYNC), .IDLE_TX(IDLE_TX)) dut (
    .clk(clk), .rst(rst), .SCK_I(sck), .SS_I(ss), .IO0_I(mosi),
    .IO1_O(io1_o), .IO1_T(io1_t),
    .spi_tx_data(tx_data), .spi_tx_valid(tx_valid), .spi_tx_ready(tx_ready),
    .spi_rx_data(rx_data), .spi_rx_valid(rx_valid), .spi_tx_underrun(underrun));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // model: accepted bytes queue in order; received bytes must match what the master sent
  always @(negedge clk) begin
    if (rst) begin
      last_rx = 0;
      prev_valid = 0;
      acc_q.delete();
      rxq.delete();
    end else begin
      if (tx_valid && tx_ready) begin
        acc_q.push_back(tx_data);
        n_acc++;
      end
      if (rx_valid) begin
        n_strobe++;
        chk("rx_strobe_width", prev_valid, 0);
        chk("rx_strobe_expected", rxq.size() > 0, 1);
        if (rxq.size() > 0) last_rx = rxq.pop_front();
      end
      chk("rx_data", rx_data, last_rx);
      if (underrun) begin
        n_under++;
        chk("underrun_expected", under_pend > 0, 1);
        if (under_pend > 0) under_pend--;
      end
      prev_valid = rx_valid;
    end
  end

  task automatic push(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1;
    for (int t = 0; t < 400 && !tx_ready; t++) tick();
    chk("push_ready", tx_ready, 1);
    tick();
    tx_valid = 0;
  endtask

  // mode-0 master: SS setup is the first low phase; last SCK fall coincides with SS rise
  task automatic xfer(input int n, input int nbits);
    ss = 0;
    for (int b = 0; b < nbits; b++) begin
      int k, i;
      k = b / 8;
      i = 7 - b % 8;
      if (i == 7) begin
        if (acc_q.size() > 0) mexp[k] = acc_q.pop_front();
        else begin
          mexp[k] = IDLE_TX;
          under_pend++;
        end
        if ((k + 1) * 8 <= nbits) rxq.push_back(mtx[k]);
      end
      mosi = mtx[k][i];
      tick(HALF);
      sck = 1;
      mrx[k][i] = io1_o;
      tick(HALF);
      sck = 0;
      if (b == nbits - 1) ss = 1;
    end
    if (nbits < n * 8) begin
      tick(SYNC + 2);
      chk("abort_io1_t", io1_t, 1);
    end else
      for (int k = 0; k < n; k++) chk("miso_byte", mrx[k], mexp[k]);
    tick(24);
  endtask

  task automatic chk_reset_vals();
    chk("rst_io1_o", io1_o, 0);
    chk("rst_io1_t", io1_t, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", underrun, 0);
  endtask

  task automatic chk_idle_model();
    chk("rx_all_seen", rxq.size(), 0);
    chk("underrun_all_seen", under_pend, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk_reset_vals();
    rst = 0;
    tick(2);
    chk_reset_vals();
    // single byte
    s0 = n_strobe;
    push(8'h3C);
    chk("sb_ready_low", tx_ready, 0);
    mtx[0] = 8'h55;
    xfer(1, 8);
    chk("sb_rx", rx_data, 8'h55);
    chk("sb_miso", mrx[0], 8'h3C);
    chk("sb_ready_back", tx_ready, 1);
    chk("sb_strobes", n_strobe - s0, 1);
    chk_idle_model();
    // back-to-back with refill inside byte 1
    s0 = n_strobe;
    u0 = n_under;
    push(8'h11);
    mtx[0] = 8'hA3;
    mtx[1] = 8'hAA;
    fork
      xfer(2, 16);
      begin
        tick(40);
        push(8'h22);
      end
    join
    chk("b2b_miso0", mrx[0], 8'h11);
    chk("b2b_miso1", mrx[1], 8'h22);
    chk("b2b_rx_last", rx_data, 8'hAA);
    chk("b2b_strobes", n_strobe - s0, 2);
    chk("b2b_no_underrun", n_under - u0, 0);
    chk_idle_model();
    // underrun
    u0 = n_under;
    mtx[0] = 8'hF0;
    xfer(1, 8);
    chk("ur_miso", mrx[0], 8'h00);
    chk("ur_rx", rx_data, 8'hF0);
    chk("ur_pulses", n_under - u0, 1);
    chk_idle_model();
    // abort after 5 SCK cycles, then a full frame
    s0 = n_strobe;
    mtx[0] = 8'hC5;
    xfer(1, 5);
    chk("ab_no_strobe", n_strobe - s0, 0);
    mtx[0] = 8'h81;
    xfer(1, 8);
    chk("ab_rx", rx_data, 8'h81);
    chk_idle_model();
    // reset mid-byte with SS held low
    ss = 0;
    under_pend++;
    tick(HALF);
    for (int b = 0; b < 3; b++) begin
      mosi = 1;
      sck = 1;
      tick(HALF);
      sck = 0;
      tick(HALF);
    end
    sck = 1;
    rst = 1;
    tick(3);
    sck = 0;
    rst = 0;
    tick();
    chk_reset_vals();
    s0 = n_strobe;
    for (int b = 0; b < 8; b++) begin
      sck = 1;
      tick(HALF);
      sck = 0;
      tick(HALF);
    end
    chk("rs_still_idle", io1_t, 1);
    chk("rs_no_strobe", n_strobe - s0, 0);
    ss = 1;
    tick(HALF);
    mtx[0] = 8'h7E;
    xfer(1, 8);
    chk("rs_rx", rx_data, 8'h7E);
    chk("rs_strobes", n_strobe - s0, 1);
    chk_idle_model();
    // ready/valid: valid held high with a byte changing every cycle
    a0 = n_acc;
    u0 = n_under;
    tx_data = 8'h40;
    tx_valid = 1;
    spin = 1;
    tick(3);
    for (int k = 0; k < 4; k++) mtx[k] = 8'h90 + 8'(k);
    fork
      begin
        xfer(4, 32);
        spin = 0;
      end
      while (spin) begin
        tick();
        tx_data = tx_data + 8'd1;
      end
    join
    tx_valid = 0;
    tick(2);
    chk("rv_accepts", n_acc - a0, 5);
    chk("rv_leftover", acc_q.size(), 1);
    chk("rv_no_underrun", n_under - u0, 0);
    chk("rv_first_byte", mrx[0], 8'h40);
    chk("rv_rx_last", rx_data, 8'h93);
    chk_idle_model();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
